// File: rtl/zero_scan_ctrl.sv
// zero_scan_ctrl
// Decides whether a wide operand is all-zero by scanning it one CHUNK_W-bit
// slice per cycle through a single narrow OR-reduction. It also reports the
// index of the lowest non-zero chunk. A start/busy/done handshake connects it
// to the surrounding sequencer.
//
// State table:
//   state | meaning
//   IDLE  | waiting for start; results from the last scan are held
//   SCAN  | examining one chunk of the shadow copy per cycle
//   DONE  | one-cycle results-valid pulse; a start here is accepted
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset; aborts a scan without done
//   start          scan request, accepted only in IDLE or DONE
//   early_exit     sampled with start; stop at the first non-zero chunk
//   data_in        operand, copied into the shadow register on accept
//   busy           high while scanning
//   done           one-cycle pulse, results valid
//   is_zero        whole operand zero
//   first_nz       index of the lowest non-zero chunk (0 when is_zero)
//   chunks_scanned number of chunks examined in the last scan
//
// DATA_W must be an integer multiple of CHUNK_W.
module zero_scan_ctrl #(
    parameter  int DATA_W     = 1024,
    parameter  int CHUNK_W    = 64,
    localparam int NUM_CHUNKS = DATA_W / CHUNK_W,
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              early_exit,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              done,
    output logic              is_zero,
    output logic [IDX_W-1:0]  first_nz,
    output logic [IDX_W:0]    chunks_scanned
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    state_t                                state;
    // The shadow copy is viewed as an array of chunks so that the slice
    // under test is a simple index select feeding one CHUNK_W-wide OR.
    logic [NUM_CHUNKS-1:0][CHUNK_W-1:0]    shadow;
    logic [IDX_W-1:0]                      idx;
    logic                                  nz_seen;
    logic                                  ee_q;
    logic                                  chunk_nz;
    logic                                  last_step;

    assign chunk_nz  = |shadow[idx];
    assign last_step = (idx == LAST_IDX) || (ee_q && chunk_nz);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            shadow         <= '0;
            idx            <= '0;
            nz_seen        <= 1'b0;
            ee_q           <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            is_zero        <= 1'b0;
            first_nz       <= '0;
            chunks_scanned <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        shadow         <= data_in;
                        ee_q           <= early_exit;
                        idx            <= '0;
                        nz_seen        <= 1'b0;
                        is_zero        <= 1'b0;
                        first_nz       <= '0;
                        chunks_scanned <= '0;
                        busy           <= 1'b1;
                        state          <= SCAN;
                    end else begin
                        state <= IDLE;
                    end
                end

                SCAN: begin
                    // start is deliberately ignored here: no restart, no error.
                    if (chunk_nz && !nz_seen) begin
                        first_nz <= idx;
                        nz_seen  <= 1'b1;
                    end
                    if (last_step) begin
                        // The current chunk has not reached nz_seen yet, so
                        // both must be folded into the verdict.
                        is_zero        <= ~(nz_seen | chunk_nz);
                        chunks_scanned <= (IDX_W+1)'(idx) + (IDX_W+1)'(1);
                        busy           <= 1'b0;
                        done           <= 1'b1;
                        state          <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zero_scan_ctrl.sv
module tb_zero_scan_ctrl;

    localparam int DW = 1024;
    localparam int CW = 64;
    localparam int NC = DW / CW;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          early_exit = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          busy;
    logic          done;
    logic          is_zero;
    logic [IW-1:0] first_nz;
    logic [IW:0]   chunks_scanned;

    typedef struct {
        logic z;
        int   fnz;
        int   cnt;
        int   cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   n_done = 0;

    zero_scan_ctrl #(.DATA_W(DW), .CHUNK_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .early_exit     (early_exit),
        .data_in        (data_in),
        .busy           (busy),
        .done           (done),
        .is_zero        (is_zero),
        .first_nz       (first_nz),
        .chunks_scanned (chunks_scanned)
    );

    always #5 clk = ~clk;

    // cyc == n during the cycle that follows edge n.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference result computed straight from the operand.
    function automatic exp_t model(input logic [DW-1:0] d, input logic ee, input int k);
        exp_t e;
        logic [CW-1:0] c;
        e.z   = 1'b1;
        e.fnz = 0;
        e.cnt = NC;
        for (int j = 0; j < NC; j++) begin
            c = d[j*CW +: CW];
            if (c != '0 && e.z) begin
                e.z   = 1'b0;
                e.fnz = j;
                if (ee) begin
                    e.cnt = j + 1;
                    break;
                end
            end
        end
        e.cyc = k + e.cnt;
        return e;
    endfunction

    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            n_done++;
            if (sb.size() == 0) begin
                chk("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("is_zero", {31'd0, is_zero}, {31'd0, e.z});
                chk("first_nz", {28'd0, first_nz}, e.fnz);
                chk("chunks_scanned", {27'd0, chunks_scanned}, e.cnt);
                chk("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_scan(input logic [DW-1:0] d, input logic ee, input bit push);
        data_in    = d;
        early_exit = ee;
        start      = 1'b1;
        if (push) sb.push_back(model(d, ee, cyc + 1));
        step();
        start      = 1'b0;
        early_exit = 1'b0;
        data_in    = '0;
        chk("acc_busy", {31'd0, busy}, 32'd1);
        chk("acc_done", {31'd0, done}, 32'd0);
        chk("acc_is_zero_clr", {31'd0, is_zero}, 32'd0);
        chk("acc_cnt_clr", {27'd0, chunks_scanned}, 32'd0);
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 100 && n_done < target; i++) step();
        chk("done_timeout", {31'd0, n_done >= target}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;

        // Reset state
        step();
        step();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_is_zero", {31'd0, is_zero}, 32'd0);
        chk("rst_first_nz", {28'd0, first_nz}, 32'd0);
        chk("rst_cnt", {27'd0, chunks_scanned}, 32'd0);
        rst = 1'b0;
        step();

        // 1: all-zero operand, full scan, then results hold
        start_scan('0, 1'b0, 1'b1);
        wait_done(1);
        repeat (3) step();
        chk("hold_is_zero", {31'd0, is_zero}, 32'd1);
        chk("hold_cnt", {27'd0, chunks_scanned}, NC);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // 2: single bit in chunk 10, with and without early exit
        d = '0;
        d[700] = 1'b1;
        start_scan(d, 1'b1, 1'b1);
        wait_done(2);
        start_scan(d, 1'b0, 1'b1);
        wait_done(3);

        // 3: bits in chunks 0 and 15; start re-pulsed mid-scan is ignored
        d = '0;
        d[5] = 1'b1;
        d[1023] = 1'b1;
        start_scan(d, 1'b0, 1'b1);
        step();
        step();
        start      = 1'b1;
        early_exit = 1'b1;
        data_in    = '0;
        step();
        start      = 1'b0;
        early_exit = 1'b0;
        chk("busy_after_ignored_start", {31'd0, busy}, 32'd1);
        wait_done(4);

        // 4: operand removed right after acceptance
        d = '0;
        d[64] = 1'b1;
        start_scan(d, 1'b0, 1'b1);
        wait_done(5);

        // 5: reset mid-scan aborts with no done pulse, then a clean scan
        d = '0;
        d[300] = 1'b1;
        start_scan(d, 1'b0, 1'b0);
        repeat (7) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_is_zero", {31'd0, is_zero}, 32'd0);
        chk("abort_first_nz", {28'd0, first_nz}, 32'd0);
        chk("abort_cnt", {27'd0, chunks_scanned}, 32'd0);
        repeat (20) step();
        chk("no_done_after_abort", n_done, 32'd5);
        start_scan(d, 1'b1, 1'b1);
        wait_done(6);

        // 6: start held high, alternating zero / non-zero operands
        start      = 1'b1;
        early_exit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = '0;
            if (i % 2 == 1) d[i*100] = 1'b1;
            data_in = d;
            sb.push_back(model(d, 1'b0, cyc + 1));
            step();
            data_in = '0;
            chk("b2b_acc_busy", {31'd0, busy}, 32'd1);
            chk("b2b_acc_is_zero_clr", {31'd0, is_zero}, 32'd0);
            chk("b2b_acc_cnt_clr", {27'd0, chunks_scanned}, 32'd0);
            repeat (NC) step();
            chk("b2b_done", {31'd0, done}, 32'd1);
        end
        start = 1'b0;
        wait_done(10);

        repeat (5) step();
        chk("scoreboard_empty", sb.size(), 32'd0);
        chk("total_done", n_done, 32'd10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
